// File: rtl/g_writeback_arbiter.sv
// Write-back arbiter: one FIFO per result source (ALU, load unit) and a round-robin
// arbiter that issues at most one register-file write per cycle.

module g_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         ready_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Ready comes from the registered count only; a same-cycle pop never frees a full FIFO.
  assign ready_o = (count_q != FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign push_ok = push_i & ready_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no path leaves one unassigned and no latch is inferred.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + PW'(1);
    if (pop_ok)  head_d = head_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is updated only with non-blocking assignments (<=); combinational logic uses blocking (=).
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= data_i;
  end
endmodule

module g_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int W_RD  = 4,
  parameter int W_OPR = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid_i,
  input  logic [W_RD-1:0]  alu_rd_i,
  input  logic [W_OPR-1:0] alu_result_i,
  output logic             alu_ready_o,
  input  logic             mem_valid_i,
  input  logic [W_RD-1:0]  mem_rd_i,
  input  logic [W_OPR-1:0] mem_result_i,
  output logic             mem_ready_o,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o,
  output logic             busy_o
);
  localparam int WE = W_RD + W_OPR;

  typedef enum logic {FAV_ALU = 1'b0, FAV_MEM = 1'b1} rr_e;

  rr_e           rr_q, rr_d;
  logic          alu_empty, mem_empty;
  logic          grant_alu, grant_mem, contended;
  logic [WE-1:0] alu_head, mem_head, wb_entry;

  g_wb_fifo #(.DEPTH(DEPTH), .W(WE)) u_alu_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (alu_valid_i),
    .data_i  ({alu_rd_i, alu_result_i}),
    .pop_i   (grant_alu),
    .ready_o (alu_ready_o),
    .empty_o (alu_empty),
    .head_o  (alu_head)
  );

  g_wb_fifo #(.DEPTH(DEPTH), .W(WE)) u_mem_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (mem_valid_i),
    .data_i  ({mem_rd_i, mem_result_i}),
    .pop_i   (grant_mem),
    .ready_o (mem_ready_o),
    .empty_o (mem_empty),
    .head_o  (mem_head)
  );

  assign contended = ~alu_empty & ~mem_empty;

  // The favour pointer only moves when both sources compete, so a lone source never costs the other its turn.
  always_comb begin
    grant_alu = ~alu_empty & (mem_empty | (rr_q == FAV_ALU));
    grant_mem = ~mem_empty & (alu_empty | (rr_q == FAV_MEM));
    rr_d      = rr_q;
    if (contended) rr_d = grant_alu ? FAV_MEM : FAV_ALU;
    wb_entry  = '0;
    if (grant_alu)      wb_entry = alu_head;
    else if (grant_mem) wb_entry = mem_head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= FAV_ALU;
    else        rr_q <= rr_d;
  end

  assign wb_o               = grant_alu | grant_mem;
  assign {wb_r_o, result_o} = wb_entry;
  assign busy_o             = ~alu_empty | ~mem_empty;
endmodule

// File: tb/tb_g_writeback_arbiter.sv
// Self-checking bench for g_writeback_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based model of the two FIFOs and the fair arbiter.

module tb_g_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int W_RD  = 4;
  localparam int W_OPR = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             alu_valid_i = 1'b0;
  logic [W_RD-1:0]  alu_rd_i = '0;
  logic [W_OPR-1:0] alu_result_i = '0;
  logic             alu_ready_o;
  logic             mem_valid_i = 1'b0;
  logic [W_RD-1:0]  mem_rd_i = '0;
  logic [W_OPR-1:0] mem_result_i = '0;
  logic             mem_ready_o;
  logic             wb_o;
  logic [W_RD-1:0]  wb_r_o;
  logic [W_OPR-1:0] result_o;
  logic             busy_o;

  int errors = 0;
  int checks = 0;

  g_writeback_arbiter #(.DEPTH(DEPTH), .W_RD(W_RD), .W_OPR(W_OPR)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid_i  (alu_valid_i),
    .alu_rd_i     (alu_rd_i),
    .alu_result_i (alu_result_i),
    .alu_ready_o  (alu_ready_o),
    .mem_valid_i  (mem_valid_i),
    .mem_rd_i     (mem_rd_i),
    .mem_result_i (mem_result_i),
    .mem_ready_o  (mem_ready_o),
    .wb_o         (wb_o),
    .wb_r_o       (wb_r_o),
    .result_o     (result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W_RD-1:0]  rd;
    logic [W_OPR-1:0] data;
  } ent_t;

  ent_t alu_mq[$];
  ent_t mem_mq[$];
  bit   last_win_alu;  // winner of the most recent contended cycle

  function automatic void model_reset();
    alu_mq.delete();
    mem_mq.delete();
    last_win_alu = 1'b0;  // ALU is favoured first after reset
  endfunction

  // 0: no grant, 1: ALU, 2: memory
  function automatic int model_grant();
    if (alu_mq.size() != 0 && mem_mq.size() != 0) return last_win_alu ? 2 : 1;
    if (alu_mq.size() != 0) return 1;
    if (mem_mq.size() != 0) return 2;
    return 0;
  endfunction

  function automatic ent_t model_head();
    int g;
    g = model_grant();
    if (g == 1) return alu_mq[0];
    if (g == 2) return mem_mq[0];
    return '0;
  endfunction

  task automatic model_clock();
    int g;
    bit ar, mr;
    g  = model_grant();
    ar = (alu_mq.size() != DEPTH);
    mr = (mem_mq.size() != DEPTH);
    if (alu_mq.size() != 0 && mem_mq.size() != 0) last_win_alu = (g == 1);
    if (g == 1)      void'(alu_mq.pop_front());
    else if (g == 2) void'(mem_mq.pop_front());
    if (alu_valid_i && ar) alu_mq.push_back(ent_t'{alu_rd_i, alu_result_i});
    if (mem_valid_i && mr) mem_mq.push_back(ent_t'{mem_rd_i, mem_result_i});
  endtask

  // Advance one clock with the model in step; returns on the following falling edge.
  task automatic tick();
    if (!reset) model_reset();
    else        model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    mem_valid_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 4'd7; alu_result_i = 32'h5555;
    mem_valid_i = 1'b1; mem_rd_i = 4'd9; mem_result_i = 32'h6666;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({wb_o, wb_r_o, result_o, busy_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: wb=%b rd=%0d res=%h busy=%b, want all 0", wb_o, wb_r_o, result_o, busy_o);
      end
      checks++;
      if ({alu_ready_o, mem_ready_o} !== 2'b11) begin
        errors++;
        $display("FAIL reset_ready: alu=%b mem=%b, want 1 1", alu_ready_o, mem_ready_o);
      end
    end
    reset = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 4'd3; alu_result_i = 32'h0000_00AA;
    mem_valid_i = 1'b0;
    #1;
    checks++;
    if (wb_o !== 1'b0) begin
      errors++;
      $display("FAIL first_push_early: wb=%b, want 0", wb_o);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({wb_o, wb_r_o, result_o} !== {1'b1, 4'd3, 32'h0000_00AA}) begin
      errors++;
      $display("FAIL first_push: wb=%b rd=%0d res=%h, want 1 3 000000aa", wb_o, wb_r_o, result_o);
    end
    tick();
    #1;
    checks++;
    if ({wb_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL first_push_drain: wb=%b busy=%b, want 0 0", wb_o, busy_o);
    end
  endtask

  task automatic test_contention();
    alu_valid_i = 1'b1; alu_rd_i = 4'd1; alu_result_i = 32'h11;
    mem_valid_i = 1'b1; mem_rd_i = 4'd2; mem_result_i = 32'h22;
    #1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({wb_o, wb_r_o, result_o} !== {1'b1, 4'd1, 32'h11}) begin
      errors++;
      $display("FAIL contention_first: wb=%b rd=%0d res=%h, want 1 1 11", wb_o, wb_r_o, result_o);
    end
    tick();
    #1;
    checks++;
    if ({wb_o, wb_r_o, result_o} !== {1'b1, 4'd2, 32'h22}) begin
      errors++;
      $display("FAIL contention_second: wb=%b rd=%0d res=%h, want 1 2 22", wb_o, wb_r_o, result_o);
    end
    tick();
    #1;
    checks++;
    if ({wb_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL contention_drain: wb=%b busy=%b, want 0 0", wb_o, busy_o);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 11; i++) begin
      alu_valid_i  = 1'b0;
      mem_valid_i  = (i < 10);
      mem_rd_i     = 4'(i);
      mem_result_i = 32'h100 + i;
      #1;
      checks++;
      if (mem_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL wrap_ready: step %0d mem_ready=%b, want 1", i, mem_ready_o);
      end
      checks++;
      if (i == 0) begin
        if (wb_o !== 1'b0) begin
          errors++;
          $display("FAIL wrap_idle: wb=%b, want 0", wb_o);
        end
      end else if ({wb_o, wb_r_o, result_o} !== {1'b1, 4'(i - 1), 32'h100 + i - 1}) begin
        errors++;
        $display("FAIL wrap_wb: step %0d got wb=%b rd=%0d res=%h, want 1 %0d %h",
                 i, wb_o, wb_r_o, result_o, i - 1, 32'h100 + i - 1);
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if ({wb_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_drain: wb=%b busy=%b, want 0 0", wb_o, busy_o);
    end
  endtask

  task automatic test_full();
    int a_sent = 0;
    int m_sent = 0;
    bit a_acc, m_acc;
    bit saw_full = 1'b0;
    logic [W_OPR-1:0] alu_got[$];
    logic [W_RD+W_OPR:0] got, want;
    logic [2:0] wflags;
    for (int cyc = 0; cyc < 120; cyc++) begin
      alu_valid_i  = (a_sent < 12);
      alu_rd_i     = 4'(4 + a_sent);
      alu_result_i = 32'hA000 + a_sent;
      mem_valid_i  = (a_sent < 12);
      mem_rd_i     = 4'(m_sent);
      mem_result_i = 32'hB000 + m_sent;
      #1;
      got  = {wb_o, wb_r_o, result_o};
      want = {model_grant() != 0, model_head()};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL full_wb: cycle %0d got %h want %h", cyc, got, want);
      end
      wflags = {alu_mq.size() != DEPTH, mem_mq.size() != DEPTH, (alu_mq.size() + mem_mq.size()) != 0};
      checks++;
      if ({alu_ready_o, mem_ready_o, busy_o} !== wflags) begin
        errors++;
        $display("FAIL full_flags: cycle %0d got rdy_a/rdy_m/busy=%b want %b", cyc,
                 {alu_ready_o, mem_ready_o, busy_o}, wflags);
      end
      if (!alu_ready_o) saw_full = 1'b1;
      if (wb_o && result_o[31:12] == 20'hA) alu_got.push_back(result_o);
      a_acc = alu_valid_i && (alu_mq.size() != DEPTH);
      m_acc = mem_valid_i && (mem_mq.size() != DEPTH);
      tick();
      if (a_acc) a_sent++;
      if (m_acc) m_sent++;
      if (a_sent == 12 && alu_mq.size() == 0 && mem_mq.size() == 0) break;
    end
    idle_inputs();
    #1;
    checks++;
    if (saw_full !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_drop: alu_ready never went low");
    end
    checks++;
    if (busy_o !== 1'b0 || alu_got.size() != 12) begin
      errors++;
      $display("FAIL full_drain: busy=%b alu write-backs=%0d, want 0 and 12", busy_o, alu_got.size());
    end
    for (int i = 0; i < alu_got.size() && i < 12; i++) begin
      checks++;
      if (alu_got[i] !== 32'hA000 + i) begin
        errors++;
        $display("FAIL full_order: slot %0d got %h want %h", i, alu_got[i], 32'hA000 + i);
      end
    end
  endtask

  task automatic test_push_pop_full1();
    int a_sent = 0;
    int m_sent = 0;
    bit hit = 1'b0;
    bit hit_now, a_acc, m_acc;
    logic [W_OPR-1:0] mem_got[$];
    logic [W_RD+W_OPR:0] got, want;
    for (int cyc = 0; cyc < 80; cyc++) begin
      alu_valid_i  = !hit;
      alu_rd_i     = 4'(a_sent);
      alu_result_i = 32'hC000 + a_sent;
      mem_valid_i  = !hit;
      mem_rd_i     = 4'(m_sent);
      mem_result_i = 32'hD000 + m_sent;
      #1;
      got  = {wb_o, wb_r_o, result_o};
      want = {model_grant() != 0, model_head()};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pushpop_wb: cycle %0d got %h want %h", cyc, got, want);
      end
      if (wb_o && result_o[31:12] == 20'hD) mem_got.push_back(result_o);
      hit_now = mem_valid_i && (mem_mq.size() == DEPTH - 1) && (model_grant() == 2);
      a_acc = alu_valid_i && (alu_mq.size() != DEPTH);
      m_acc = mem_valid_i && (mem_mq.size() != DEPTH);
      tick();
      if (a_acc) a_sent++;
      if (m_acc) m_sent++;
      if (hit_now) begin
        hit = 1'b1;
        #1;
        checks++;
        if ({mem_ready_o, busy_o} !== 2'b11) begin
          errors++;
          $display("FAIL pushpop_ready: mem_ready=%b busy=%b, want 1 1", mem_ready_o, busy_o);
        end
      end
      if (hit && alu_mq.size() == 0 && mem_mq.size() == 0) break;
    end
    idle_inputs();
    #1;
    checks++;
    if (hit !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_scenario: reached=%b busy=%b, want 1 0", hit, busy_o);
    end
    checks++;
    if (mem_got.size() != m_sent) begin
      errors++;
      $display("FAIL pushpop_count: mem write-backs=%0d want %0d", mem_got.size(), m_sent);
    end
    for (int i = 0; i < mem_got.size(); i++) begin
      checks++;
      if (mem_got[i] !== 32'hD000 + i) begin
        errors++;
        $display("FAIL pushpop_order: slot %0d got %h want %h", i, mem_got[i], 32'hD000 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      alu_valid_i = 1'b1; alu_rd_i = 4'(10 + i); alu_result_i = 32'hE000 + i;
      mem_valid_i = 1'b1; mem_rd_i = 4'(i);      mem_result_i = 32'hF000 + i;
      #1;
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if ({wb_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_pending: wb=%b busy=%b, want 1 1", wb_o, busy_o);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({wb_o, busy_o, alu_ready_o, mem_ready_o} !== 4'b0011) begin
      errors++;
      $display("FAIL midreset_async: wb=%b busy=%b rdy_a=%b rdy_m=%b, want 0 0 1 1",
               wb_o, busy_o, alu_ready_o, mem_ready_o);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({wb_o, busy_o} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_after: cycle %0d wb=%b rd=%0d res=%h busy=%b, want no write-back",
                 i, wb_o, wb_r_o, result_o, busy_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [W_RD+W_OPR:0] got, want;
    logic [2:0] wflags;
    for (int cyc = 0; cyc < 340; cyc++) begin
      alu_valid_i  = (cyc < 300) && ($urandom_range(0, 99) < 60);
      alu_rd_i     = 4'($urandom_range(0, 15));
      alu_result_i = $urandom;
      mem_valid_i  = (cyc < 300) && ($urandom_range(0, 99) < 60);
      mem_rd_i     = 4'($urandom_range(0, 15));
      mem_result_i = $urandom;
      #1;
      got  = {wb_o, wb_r_o, result_o};
      want = {model_grant() != 0, model_head()};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_wb: cycle %0d got %h want %h", cyc, got, want);
      end
      wflags = {alu_mq.size() != DEPTH, mem_mq.size() != DEPTH, (alu_mq.size() + mem_mq.size()) != 0};
      checks++;
      if ({alu_ready_o, mem_ready_o, busy_o} !== wflags) begin
        errors++;
        $display("FAIL random_flags: cycle %0d got rdy_a/rdy_m/busy=%b want %b", cyc,
                 {alu_ready_o, mem_ready_o, busy_o}, wflags);
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: busy=%b, want 0", busy_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_contention();
    test_wrap();
    test_full();
    test_push_pop_full1();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
